fft_pair_feeder: RTL and testbench
==================================

# fft_pair_feeder

Radix-2 DIF operand-pairing stage that sits directly upstream of the clocked floating-point adder wrapper in the FFT datapath. It accepts a stream of IEEE-754 single-precision samples and stores the first half of each frame. It pairs each later sample x[n+DEPTH] with its stored partner x[n] and drives the adder's two operand inputs and its enable. It also generates a result-valid strobe aligned with the adder's registered output.

## Interface
- DATA_WIDTH, 32, sample width (FP32 bit pattern, not interpreted)
- DEPTH, 8, half-frame length N/2; power of two, >= 2
- ADD_LAT, 3, internal pipeline latency of the floating-point adder core in cycles
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  DATA_WIDTH  input sample
- frame_start  in  1  qualified by in_valid; marks sample index 0 of a frame
- pair_a  out  DATA_WIDTH  stored operand x[n]; connects to adder data_in_1
- pair_b  out  DATA_WIDTH  incoming operand x[n+DEPTH]; connects to adder data_in_2
- pair_valid  out  1  pair_a/pair_b hold a real pair this cycle
- pair_idx  out  $clog2(DEPTH)  n of the current pair
- ena_add  out  1  connects to adder ena_add_fp_clk
- res_valid  out  1  adder data_out holds the sum of a real pair this cycle
- frame_abort  out  1  one-cycle pulse: frame_start arrived mid-frame
- busy  out  1  state != IDLE or drain counter != 0

## Operation
- Reset: state IDLE, sample counter 0, drain counter 0, valid shift register 0. All outputs are 0. Buffer contents are don't-care.
- States:
  - IDLE: any in_valid (frame_start optional) stores in_data at index 0, counter=1, goes to FILL.
  - FILL: each in_valid stores at index=counter and increments the counter. The write at counter DEPTH-1 moves to PAIR with counter=0.
  - PAIR: each in_valid registers pair_a=buf[counter], pair_b=in_data, pair_idx=counter, pair_valid=1, then increments the counter. The pair at counter DEPTH-1 returns to IDLE.
- Input gaps (in_valid=0) are legal in FILL and PAIR. In a gap cycle, pair_valid=0 and pair_a/pair_b=0 on the next cycle.
- frame_start with in_valid in FILL or PAIR:
  - the partial frame is dropped;
  - frame_abort pulses;
  - in_data is stored at index 0, counter=1, state FILL.
  - frame_start with in_valid in IDLE is a normal start with no abort. frame_start without in_valid is ignored.
- Drain counter:
  - loaded with ADD_LAT+2 on every cycle a pair is issued;
  - otherwise decrements when nonzero;
  - it runs independently of state, so a restart never truncates in-flight results.
- ena_add = (state==PAIR) or (drain counter != 0). It stays high through PAIR input gaps so the adder pipeline never freezes with real data inside.
- res_valid: shift register of length ADD_LAT+2 fed by pair_valid, shifted every cycle.
- Data is passed bit-exact. The block performs no arithmetic.

## Timing
- All outputs are registered.
- Sample in cycle t → pair outputs valid in cycle t+1.
- pair_valid in cycle t+1 → res_valid in cycle t+1+ADD_LAT+2. This covers the wrapper's input register, the adder core, and the wrapper's output register.
- ena_add rises in the cycle after the first PAIR-state transition. It falls ADD_LAT+2 cycles after the last pair_valid cycle.
- Back-to-back frames: the first sample of the next frame may arrive in the cycle after the last pair sample (IDLE → FILL). No bubble is required.
- Reset mid-frame clears everything at once, and res_valid drops immediately. No partial results are reported.

## Structure
- Shared FFT package holds:
  - the FP32 width constant;
  - the state encoding (IDLE, FILL, PAIR);
  - the helper for the index width.
- One sub-module, fft_pair_buf: a DEPTH×DATA_WIDTH register file with one write port (index, data, we) and a combinational read port. No reset on the storage.
- The counter, FSM, drain counter and valid shift register live in the top module.

## Test plan
All scenarios use DEPTH=4, ADD_LAT=3.

1. Contiguous frame 1.0,2.0,3.0,4.0,5.0,6.0,7.0,8.0 (0x3F800000…) → pairs (1,5),(2,6),(3,7),(4,8) with pair_idx 0..3 in consecutive cycles, each 1 cycle after its sample. Adder out reads 6,8,10,12 with res_valid 5 cycles after each pair_valid.
2. Same frame with one idle cycle after samples 2 and 6 → ena_add stays high across the PAIR gap. Exactly 4 res_valid pulses appear, with one gap, and sums are unchanged.
3. frame_start on the 6th sample (index 1 of PAIR) → frame_abort pulses once, the earlier pair still yields res_valid, and the new frame pairs its own samples correctly.
4. Two frames back-to-back with no gap → 8 pairs and 8 res_valid pulses. ena_add never drops between frames. busy falls 5 cycles after the last pair.
5. rst_n asserted during PAIR with a pair in flight → all outputs 0 immediately. After release, a fresh frame behaves as in scenario 1.
6. frame_start without in_valid in FILL → ignored, and the fill continues at the next index.

Source files
------------

// File: rtl/fft_pair_feeder_pkg.sv
// rtl/fft_pair_feeder_pkg.sv - shared FFT constants, pairing FSM states and index-width helper
package fft_pair_feeder_pkg;

    localparam int FP32_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAIR = 2'd2
    } pair_state_t;

    function automatic int idx_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fft_pair_buf.sv
// rtl/fft_pair_buf.sv - half-frame sample store, one write port and a combinational read port
module fft_pair_buf
    import fft_pair_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = FP32_WIDTH,
    parameter int DEPTH      = 8,
    parameter int IW         = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are only read after being written in the same frame, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_pair_feeder.sv
// rtl/fft_pair_feeder.sv - radix-2 DIF pairing of x[n] with x[n+DEPTH] feeding the FP adder wrapper
module fft_pair_feeder
    import fft_pair_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = FP32_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ADD_LAT    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       frame_start,
    output logic [DATA_WIDTH-1:0]      pair_a,
    output logic [DATA_WIDTH-1:0]      pair_b,
    output logic                       pair_valid,
    output logic [$clog2(DEPTH)-1:0]   pair_idx,
    output logic                       ena_add,
    output logic                       res_valid,
    output logic                       frame_abort,
    output logic                       busy
);

    localparam int IW  = idx_width(DEPTH);
    localparam int VL  = ADD_LAT + 2;
    localparam int DRW = $clog2(VL + 1);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(DEPTH - 1);
    localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(VL);

    pair_state_t           state, next_state;
    logic [IW-1:0]         cnt, next_cnt;
    logic [DRW-1:0]        drain, next_drain;
    logic [VL-1:0]         vsr;
    logic                  we, issue, abort;
    logic [IW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] rdata;

    fft_pair_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (cnt),
        .rdata (rdata)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        we         = 1'b0;
        waddr      = cnt;
        issue      = 1'b0;
        abort      = 1'b0;
        if (in_valid && (state == ST_IDLE || frame_start)) begin
            // A start outside IDLE discards the partial frame and restarts the fill.
            abort      = (state != ST_IDLE);
            we         = 1'b1;
            waddr      = '0;
            next_cnt   = IW'(1);
            next_state = ST_FILL;
        end else if (in_valid) begin
            case (state)
                ST_FILL: begin
                    we       = 1'b1;
                    next_cnt = cnt + IW'(1);
                    if (cnt == LAST_IDX) begin
                        next_cnt   = '0;
                        next_state = ST_PAIR;
                    end
                end
                ST_PAIR: begin
                    issue    = 1'b1;
                    next_cnt = cnt + IW'(1);
                    if (cnt == LAST_IDX) begin
                        next_cnt   = '0;
                        next_state = ST_IDLE;
                    end
                end
                default: begin
                    next_cnt   = '0;
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Drain keeps the adder clocked until the last issued pair has left its output register.
    always_comb begin
        next_drain = drain;
        if (issue) begin
            next_drain = DRAIN_LOAD;
        end else if (drain != '0) begin
            next_drain = drain - DRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            drain       <= '0;
            vsr         <= '0;
            pair_a      <= '0;
            pair_b      <= '0;
            pair_valid  <= 1'b0;
            pair_idx    <= '0;
            ena_add     <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            drain       <= next_drain;
            vsr         <= {vsr[VL-2:0], pair_valid};
            pair_valid  <= issue;
            pair_a      <= issue ? rdata : '0;
            pair_b      <= issue ? in_data : '0;
            pair_idx    <= issue ? cnt : '0;
            frame_abort <= abort;
            ena_add     <= (next_state == ST_PAIR) || (next_drain != '0);
            busy        <= (next_state != ST_IDLE) || (next_drain != '0);
        end
    end

    assign res_valid = vsr[VL-1];

endmodule

// File: tb/tb_fft_pair_feeder.sv
// tb/tb_fft_pair_feeder.sv - directed and random stimulus against a frame-level reference model
module tb_fft_pair_feeder;

    localparam int DW  = 32;
    localparam int D   = 4;
    localparam int AL  = 3;
    localparam int IW  = 2;
    localparam int LAT = AL + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] pair_a, pair_b;
    logic          pair_valid, ena_add, res_valid, frame_abort, busy;
    logic [IW-1:0] pair_idx;

    fft_pair_feeder #(.DATA_WIDTH(DW), .DEPTH(D), .ADD_LAT(AL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_start (frame_start),
        .pair_a      (pair_a),
        .pair_b      (pair_b),
        .pair_valid  (pair_valid),
        .pair_idx    (pair_idx),
        .ena_add     (ena_add),
        .res_valid   (res_valid),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [DW-1:0] frame_q [$];
    int            pair_cyc [$];
    logic [DW-1:0] fp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic fs, input logic [DW-1:0] d);
        logic          ev, eab, er, recent;
        logic [DW-1:0] ea, eb;
        logic [IW-1:0] ei;
        int            n;
        in_valid    = v;
        frame_start = fs;
        in_data     = d;
        @(posedge clk);
        #1;
        cyc++;
        ev = 1'b0; eab = 1'b0; ea = '0; eb = '0; ei = '0;
        if (v) begin
            if (fs && frame_q.size() != 0) begin
                eab = 1'b1;
                frame_q.delete();
            end
            frame_q.push_back(d);
            n = frame_q.size();
            if (n > D) begin
                ev = 1'b1;
                ea = frame_q[n-1-D];
                eb = d;
                ei = IW'(n - 1 - D);
            end
            if (n == 2 * D) frame_q.delete();
        end
        if (ev) pair_cyc.push_back(cyc);
        while (pair_cyc.size() > 0 && pair_cyc[0] < cyc - LAT) void'(pair_cyc.pop_front());
        er = (pair_cyc.size() > 0 && pair_cyc[0] == cyc - LAT);
        recent = 1'b0;
        foreach (pair_cyc[i]) if (pair_cyc[i] > cyc - LAT) recent = 1'b1;
        check("pair_valid", 32'(pair_valid), 32'(ev));
        check("pair_a", pair_a, ea);
        check("pair_b", pair_b, eb);
        check("pair_idx", 32'(pair_idx), 32'(ei));
        check("frame_abort", 32'(frame_abort), 32'(eab));
        check("res_valid", 32'(res_valid), 32'(er));
        check("ena_add", 32'(ena_add), 32'(frame_q.size() >= D || recent));
        check("busy", 32'(busy), 32'(frame_q.size() != 0 || recent));
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic reset_check();
        #2 rst_n = 1'b0;
        #1;
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_pair_a", pair_a, 32'd0);
        check("rst_pair_b", pair_b, 32'd0);
        check("rst_pair_idx", 32'(pair_idx), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_ena_add", 32'(ena_add), 32'd0);
        check("rst_frame_abort", 32'(frame_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        frame_q.delete();
        pair_cyc.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        reset_check();

        // contiguous reference frame
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, fp[i]);
        idle(7);

        // gaps after samples 2 and 6
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, fp[i]);
            if (i == 1 || i == 5) idle(1);
        end
        idle(7);

        // restart on the sixth sample
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, fp[i]);
        step(1'b1, 1'b1, fp[5]);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, $urandom);
        idle(7);

        // two frames back-to-back
        for (int i = 0; i < 16; i++) step(1'b1, (i % 8) == 0, $urandom);
        idle(7);

        // reset with a pair in flight, then a clean frame
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, fp[i]);
        reset_check();
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, fp[i]);
        idle(7);

        // frame_start without in_valid during fill
        step(1'b1, 1'b1, fp[0]);
        step(1'b1, 1'b0, fp[1]);
        step(1'b0, 1'b1, 32'hDEADBEEF);
        for (int i = 2; i < 8; i++) step(1'b1, 1'b0, fp[i]);
        idle(7);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom);
        idle(7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
